// File: rtl/stage_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB stage sequencer: emits one-cycle stage enables,
// waits on fetch/memory handshakes, and tracks halt, bus timeout and counters.
module stage_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req,
  input  logic             inst_ready,
  output logic             mem_req,
  input  logic             mem_ready,
  input  logic             need_mem,
  input  logic             need_wb,
  input  logic             halt_req,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             retire,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [TO_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic              need_wb_reg, need_wb_next;
  logic [CNT_W-1:0]  retired_cnt_reg, cycle_cnt_reg;

  logic inst_req_c, mem_req_c, if_en_c, id_en_c, ex_en_c, mem_en_c, wb_en_c;
  logic retire_c, halted_c, bus_error_c, waiting_c, timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TO_LIMIT);

  always_comb begin
    state_next   = state_reg;
    need_wb_next = need_wb_reg;
    inst_req_c   = 1'b0;
    mem_req_c    = 1'b0;
    if_en_c      = 1'b0;
    id_en_c      = 1'b0;
    ex_en_c      = 1'b0;
    mem_en_c     = 1'b0;
    wb_en_c      = 1'b0;
    retire_c     = 1'b0;
    halted_c     = 1'b0;
    bus_error_c  = 1'b0;
    waiting_c    = 1'b0;

    case (state_reg)
      S_IF: begin
        inst_req_c = 1'b1;
        if (inst_ready) begin
          if_en_c    = 1'b1;
          state_next = S_ID;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end else begin
          waiting_c = 1'b1;
        end
      end
      S_ID: begin
        id_en_c    = 1'b1;
        state_next = S_EX;
      end
      S_EX: begin
        ex_en_c      = 1'b1;
        need_wb_next = need_wb;
        if (need_mem)     state_next = S_MEM;
        else if (need_wb) state_next = S_WB;
        else              retire_c   = 1'b1;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          mem_en_c = 1'b1;
          if (need_wb_reg) state_next = S_WB;
          else             retire_c   = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end else begin
          waiting_c = 1'b1;
        end
      end
      S_WB: begin
        wb_en_c  = 1'b1;
        retire_c = 1'b1;
      end
      S_HALT: begin
        halted_c = 1'b1;
        if (!halt_req) state_next = S_IF;
      end
      S_ERR: begin
        bus_error_c = 1'b1;
      end
      default: state_next = S_IF;
    endcase

    // Halt is only honoured at an instruction boundary.
    if (retire_c) state_next = halt_req ? S_HALT : S_IF;

    if (state_next != state_reg) wait_cnt_next = '0;
    else if (waiting_c)          wait_cnt_next = wait_cnt_reg + TO_W'(1);
    else                         wait_cnt_next = wait_cnt_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IF;
      wait_cnt_reg    <= '0;
      need_wb_reg     <= 1'b0;
      retired_cnt_reg <= '0;
      cycle_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      need_wb_reg  <= need_wb_next;
      if (retire_c)
        retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
      if (state_reg != S_HALT && state_reg != S_ERR)
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
    end
  end

  // Outputs are forced idle while reset is held, since the reset state is S_IF.
  assign inst_req    = rst & inst_req_c;
  assign mem_req     = rst & mem_req_c;
  assign if_en       = rst & if_en_c;
  assign id_en       = rst & id_en_c;
  assign ex_en       = rst & ex_en_c;
  assign mem_en      = rst & mem_en_c;
  assign wb_en       = rst & wb_en_c;
  assign retire      = rst & retire_c;
  assign halted      = rst & halted_c;
  assign bus_error   = rst & bus_error_c;
  assign retired_cnt = retired_cnt_reg;
  assign cycle_cnt   = cycle_cnt_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two instances (wide and 4-bit counters) share
// stimulus; expected outputs come from an instruction-level plan per instruction.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_ready = 1'b0, mem_ready = 1'b0, need_mem = 1'b0, need_wb = 1'b0;
  logic halt_req = 1'b0;

  always #5 clk = ~clk;

  logic        w_ireq, w_mreq, w_if, w_id, w_ex, w_mem, w_wb, w_ret, w_hlt, w_err;
  logic [15:0] w_rcnt, w_ccnt;
  logic        n_ireq, n_mreq, n_if, n_id, n_ex, n_mem, n_wb, n_ret, n_hlt, n_err;
  logic [3:0]  n_rcnt, n_ccnt;

  stage_sequencer #(.CNT_W(16), .TIMEOUT(4), .TO_W(8)) dut_w (
    .clk(clk), .rst(rst), .inst_req(w_ireq), .inst_ready(inst_ready),
    .mem_req(w_mreq), .mem_ready(mem_ready), .need_mem(need_mem), .need_wb(need_wb),
    .halt_req(halt_req), .if_en(w_if), .id_en(w_id), .ex_en(w_ex), .mem_en(w_mem),
    .wb_en(w_wb), .retire(w_ret), .halted(w_hlt), .bus_error(w_err),
    .retired_cnt(w_rcnt), .cycle_cnt(w_ccnt));

  stage_sequencer #(.CNT_W(4), .TIMEOUT(4), .TO_W(3)) dut_n (
    .clk(clk), .rst(rst), .inst_req(n_ireq), .inst_ready(inst_ready),
    .mem_req(n_mreq), .mem_ready(mem_ready), .need_mem(need_mem), .need_wb(need_wb),
    .halt_req(halt_req), .if_en(n_if), .id_en(n_id), .ex_en(n_ex), .mem_en(n_mem),
    .wb_en(n_wb), .retire(n_ret), .halted(n_hlt), .bus_error(n_err),
    .retired_cnt(n_rcnt), .cycle_cnt(n_ccnt));

  logic [9:0] vec_w, vec_n;
  assign vec_w = {w_ireq, w_mreq, w_if, w_id, w_ex, w_mem, w_wb, w_ret, w_hlt, w_err};
  assign vec_n = {n_ireq, n_mreq, n_if, n_id, n_ex, n_mem, n_wb, n_ret, n_hlt, n_err};

  localparam logic [9:0] IREQ = 10'b10_0000_0000;
  localparam logic [9:0] MREQ = 10'b01_0000_0000;
  localparam logic [9:0] IFE  = 10'b00_1000_0000;
  localparam logic [9:0] IDE  = 10'b00_0100_0000;
  localparam logic [9:0] EXE  = 10'b00_0010_0000;
  localparam logic [9:0] MEME = 10'b00_0001_0000;
  localparam logic [9:0] WBE  = 10'b00_0000_1000;
  localparam logic [9:0] RET  = 10'b00_0000_0100;
  localparam logic [9:0] HLT  = 10'b00_0000_0010;
  localparam logic [9:0] ERR  = 10'b00_0000_0001;

  int n_pass = 0;
  int n_total = 0;
  int unsigned m_ret = 0;
  int unsigned m_cyc = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_counters();
    chk("retired_cnt_w", 32'(w_rcnt), m_ret & 32'hFFFF);
    chk("cycle_cnt_w",   32'(w_ccnt), m_cyc & 32'hFFFF);
    chk("retired_cnt_n", 32'(n_rcnt), m_ret & 32'hF);
    chk("cycle_cnt_n",   32'(n_ccnt), m_cyc & 32'hF);
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic ir, input logic mr, input logic nm, input logic nw,
                      input logic hr, input logic [9:0] exp);
    chk_counters();
    inst_ready = ir; mem_ready = mr; need_mem = nm; need_wb = nw; halt_req = hr;
    #1;
    chk("outputs_w", 32'(vec_w), 32'(exp));
    chk("outputs_n", 32'(vec_n), 32'(exp));
    if ((exp & (HLT | ERR)) == 10'd0) m_cyc++;
    if ((exp & RET) != 10'd0) m_ret++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; inst_ready = 1'b1; mem_ready = 1'b1; halt_req = 1'b1;
    #1;
    chk("reset_outputs_w", 32'(vec_w), 32'd0);
    chk("reset_outputs_n", 32'(vec_n), 32'd0);
    m_ret = 0; m_cyc = 0;
    chk_counters();
    @(negedge clk);
    inst_ready = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    rst = 1'b1;
  endtask

  // One instruction: fetch waits fw, memory waits mw, optional halt held hh cycles.
  task automatic do_instr(input int fw, input logic nm, input logic nw, input int mw,
                          input logic hlt, input int hh);
    logic ex_ret, last, r;
    for (int i = 0; i <= fw; i++)
      step(i == fw, rb(), rb(), rb(), rb(), (i == fw) ? (IREQ | IFE) : IREQ);
    step(rb(), rb(), rb(), rb(), rb(), IDE);
    ex_ret = !nm && !nw;
    step(rb(), rb(), nm, nw, ex_ret ? hlt : rb(), ex_ret ? (EXE | RET) : EXE);
    if (nm) begin
      for (int j = 0; j <= mw; j++) begin
        last = (j == mw);
        r = last && !nw;
        step(rb(), last, rb(), rb(), r ? hlt : rb(),
             last ? (MREQ | MEME | (r ? RET : 10'd0)) : MREQ);
      end
    end
    if (nw) step(rb(), rb(), rb(), rb(), hlt, WBE | RET);
    if (hlt) begin
      for (int k = 0; k < hh; k++) step(rb(), rb(), rb(), rb(), 1'b1, HLT);
      step(rb(), rb(), rb(), rb(), 1'b0, HLT);
    end
  endtask

  initial begin
    #1;
    do_reset();
    do_instr(0, 1'b0, 1'b0, 0, 1'b0, 0);   // ALU, zero-wait
    do_instr(2, 1'b1, 1'b1, 3, 1'b0, 0);   // load
    do_instr(0, 1'b1, 1'b0, 1, 1'b0, 0);   // store
    do_instr(0, 1'b0, 1'b1, 0, 1'b1, 1);   // halt at retire
    do_instr(1, 1'b1, 1'b1, 0, 1'b1, 3);
    do_instr(4, 1'b1, 1'b0, 4, 1'b0, 0);   // ready exactly at the timeout count

    do_reset();
    repeat (16) do_instr(0, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_counters();

    repeat (150)
      do_instr($urandom_range(0, 4), rb(), rb(), $urandom_range(0, 4),
               ($urandom_range(0, 4) == 0), $urandom_range(1, 3));

    // Asynchronous reset while waiting in MEM.
    step(1'b1, rb(), rb(), rb(), rb(), IREQ | IFE);
    step(rb(), rb(), rb(), rb(), rb(), IDE);
    step(rb(), rb(), 1'b1, 1'b1, rb(), EXE);
    step(rb(), 1'b0, rb(), rb(), rb(), MREQ);
    step(rb(), 1'b0, rb(), rb(), rb(), MREQ);
    inst_ready = 1'b1; mem_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("midmem_reset_w", 32'(vec_w), 32'd0);
    chk("midmem_reset_n", 32'(vec_n), 32'd0);
    m_ret = 0; m_cyc = 0;
    chk_counters();
    @(negedge clk);
    inst_ready = 1'b0;
    rst = 1'b1;

    // MEM timeout.
    do_instr(0, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, rb(), rb(), rb(), rb(), IREQ | IFE);
    step(rb(), rb(), rb(), rb(), rb(), IDE);
    step(rb(), rb(), 1'b1, rb(), rb(), EXE);
    repeat (5) step(rb(), 1'b0, rb(), rb(), rb(), MREQ);
    repeat (3) step(rb(), rb(), rb(), rb(), rb(), ERR);
    do_reset();

    // Fetch timeout.
    repeat (5) step(1'b0, rb(), rb(), rb(), rb(), IREQ);
    repeat (3) step(rb(), rb(), rb(), rb(), rb(), ERR);
    chk_counters();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
